// File: rtl/fetch_unit.sv
// Instruction prefetcher: streams word reads from memory into a small queue and
// flushes/restarts on redirect, discarding a response that was already in flight.
//   state   | meaning
//   S_FETCH | normal fetching while the queue has room
//   S_DRAIN | waiting out one stale response before restarting at pending_pc
module fetch_unit #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h1000)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [XLEN-1:0]            mem_rdata,
  input  logic                       mem_resp,
  output logic                       mem_read,
  output logic [XLEN-1:0]            mem_addr,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [XLEN-1:0]            instr,
  output logic [XLEN-1:0]            instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);
  localparam logic [XLEN-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  typedef enum logic {S_FETCH, S_DRAIN} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic [XLEN-1:0]   pending_pc_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [XLEN-1:0]   data_q [DEPTH];
  logic [XLEN-1:0]   pc_q   [DEPTH];

  logic [XLEN-1:0]   target_pc;
  logic              push;
  logic              pop;
  logic              outstanding;

  assign target_pc   = redirect_pc & ALIGN_MASK;
  // Request is gated by rst_n so it is low for the whole reset window.
  assign mem_read    = rst_n & ((state_q == S_DRAIN) | (count_q < CW'(DEPTH)));
  assign mem_addr    = fetch_pc_q;
  assign outstanding = mem_read & ~mem_resp;
  assign push        = (state_q == S_FETCH) & mem_read & mem_resp & ~redirect;
  assign pop         = instr_valid & instr_ready & ~redirect;

  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];
  assign count       = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC_AL;
      pending_pc_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (pop && !push) count_q <= count_q - CW'(1);
      end

      case (state_q)
        S_FETCH: begin
          if (redirect) begin
            if (outstanding) begin
              pending_pc_q <= target_pc;
              state_q      <= S_DRAIN;
            end else begin
              fetch_pc_q <= target_pc;
            end
          end else if (push) begin
            fetch_pc_q <= fetch_pc_q + XLEN'(4);
          end
        end
        S_DRAIN: begin
          // The in-flight response completes here; its data is dropped.
          if (mem_resp) begin
            fetch_pc_q <= redirect ? target_pc : pending_pc_q;
            state_q    <= S_FETCH;
          end else if (redirect) begin
            pending_pc_q <= target_pc;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_rdata;
      pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a zero-latency memory that can be stalled,
// and scripted consumer/redirect sequences checked at negative clock edges.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  count;

  logic        mem_en;
  int          n_checks;
  int          n_pass;
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h1000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
  endfunction

  // Memory answers in the same cycle as the request whenever enabled.
  always begin
    @(posedge clk);
    #2;
    mem_resp  = mem_read & mem_en;
    mem_rdata = mem_resp ? mem_word(mem_addr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect) begin
      pop_pc.push_back(instr_pc);
      pop_instr.push_back(instr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic en);
    @(negedge clk);
    rst_n       = 1'b0;
    mem_en      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    #1;
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", mem_addr, 32'h1000);
    repeat (2) tick();
    pop_pc.delete();
    pop_instr.delete();
    rst_n  = 1'b1;
    mem_en = en;
    #1;
    chk("rel_mem_read", 32'(mem_read), 32'd1);
    chk("rel_addr", mem_addr, 32'h1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    mem_en      = 1'b0;
    mem_resp    = 1'b0;
    mem_rdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;

    // Streaming at one word per cycle.
    do_reset(1'b1);
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s1_addr", mem_addr, 32'h1000 + 32'(4 * i));
      if (i > 0) chk("s1_pc", instr_pc, 32'h1000 + 32'(4 * (i - 1)));
    end
    tick();
    chk("s1_pc_last", instr_pc, 32'h1008);
    chk("s1_instr", instr, mem_word(32'h1008));
    chk("s1_count", 32'(count), 32'd1);

    // Backpressure fills the queue, one pop reopens fetch, idle redirect.
    do_reset(1'b1);
    repeat (5) tick();
    chk("s2_count_full", 32'(count), 32'd4);
    chk("s2_read_full", 32'(mem_read), 32'd0);
    chk("s2_addr_full", mem_addr, 32'h1010);
    chk("s2_head_pc", instr_pc, 32'h1000);
    chk("s2_head_instr", instr, mem_word(32'h1000));
    tick();
    chk("s2_count_hold", 32'(count), 32'd4);
    chk("s2_head_stable", instr_pc, 32'h1000);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("s2_read_reopen", 32'(mem_read), 32'd1);
    chk("s2_count_pop", 32'(count), 32'd3);
    chk("s2_head_next", instr_pc, 32'h1004);
    tick();
    chk("s2_count_refull", 32'(count), 32'd4);
    redirect    = 1'b1;
    redirect_pc = 32'h2ABF;
    tick();
    redirect = 1'b0;
    chk("s2_idle_rd_count", 32'(count), 32'd0);
    chk("s2_idle_rd_addr", mem_addr, 32'h2ABC);
    chk("s2_idle_rd_read", 32'(mem_read), 32'd1);

    // Redirect coinciding with a response, queue holding three words.
    do_reset(1'b1);
    repeat (4) tick();
    chk("s3_count3", 32'(count), 32'd3);
    redirect    = 1'b1;
    redirect_pc = 32'h2002;
    tick();
    redirect    = 1'b0;
    instr_ready = 1'b1;
    chk("s3_count0", 32'(count), 32'd0);
    chk("s3_valid0", 32'(instr_valid), 32'd0);
    chk("s3_addr", mem_addr, 32'h2000);
    tick();
    chk("s3_valid1", 32'(instr_valid), 32'd1);
    chk("s3_pc", instr_pc, 32'h2000);
    chk("s3_instr", instr, mem_word(32'h2000));

    // Redirect while a request is stalled: the stale word is drained.
    do_reset(1'b1);
    instr_ready = 1'b1;
    tick();
    tick();
    mem_en = 1'b0;
    tick();
    chk("s4_addr_pend", mem_addr, 32'h1008);
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("s4_addr_hold", mem_addr, 32'h1008);
      chk("s4_read_hold", 32'(mem_read), 32'd1);
      tick();
    end
    chk("s4_addr_hold", mem_addr, 32'h1008);
    mem_en = 1'b1;
    tick();
    chk("s4_addr_resp", mem_addr, 32'h1008);
    chk("s4_valid_drain", 32'(instr_valid), 32'd0);
    tick();
    chk("s4_addr_new", mem_addr, 32'h3000);
    tick();
    chk("s4_pc_new", instr_pc, 32'h3000);
    tick();
    begin
      int n_stale = 0;
      foreach (pop_pc[i]) if (pop_pc[i] == 32'h1008) n_stale++;
      chk("s4_no_stale", 32'(n_stale), 32'd0);
    end

    // Repeated redirects in DRAIN, then a redirect alongside the drain response.
    do_reset(1'b0);
    instr_ready = 1'b1;
    tick();
    chk("s5_addr0", mem_addr, 32'h1000);
    redirect    = 1'b1;
    redirect_pc = 32'h3333;
    tick();
    redirect_pc = 32'h4000;
    tick();
    redirect_pc = 32'h5000;
    tick();
    redirect = 1'b0;
    mem_en   = 1'b1;
    chk("s5_addr_hold", mem_addr, 32'h1000);
    tick();
    chk("s5_addr_resp", mem_addr, 32'h1000);
    tick();
    chk("s5_addr_new", mem_addr, 32'h5000);
    mem_en = 1'b0;
    tick();
    chk("s5_addr_next", mem_addr, 32'h5004);
    redirect    = 1'b1;
    redirect_pc = 32'h6000;
    tick();
    redirect = 1'b0;
    mem_en   = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h7006;
    tick();
    redirect = 1'b0;
    chk("s5_addr_late_rd", mem_addr, 32'h7004);

    // Simultaneous push/pop at count 2 and ordered delivery across wrap.
    do_reset(1'b1);
    repeat (3) tick();
    chk("s6_count_pre", 32'(count), 32'd2);
    instr_ready = 1'b1;
    tick();
    chk("s6_count_pp", 32'(count), 32'd2);
    tick();
    chk("s6_count_pp2", 32'(count), 32'd2);
    for (int c = 0; c < 40 && pop_pc.size() < 10; c++) tick();
    chk("s6_npop", 32'(pop_pc.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < pop_pc.size(); i++) begin
      chk("s6_pc", pop_pc[i], 32'h1000 + 32'(4 * i));
      chk("s6_instr", pop_instr[i], mem_word(32'h1000 + 32'(4 * i)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the address and instruction width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the prefetch queue entry count (power of two, >=2).
REQ-003 The block SHALL have parameter RESET_PC, default 32'h1000, meaning the first fetch address after reset.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port mem_rdata  input  XLEN  read data, valid when mem_resp=1.
REQ-007 The block SHALL have port mem_resp  input  1  memory completion for the current request.
REQ-008 The block SHALL have port mem_read  output  1  read request.
REQ-009 The block SHALL have port mem_addr  output  XLEN  word-aligned fetch address.
REQ-010 The block SHALL have port redirect  input  1  flush and restart fetch at redirect_pc.
REQ-011 The block SHALL have port redirect_pc  input  XLEN  new fetch target.
REQ-012 The block SHALL have port instr_valid  output  1  queue head valid.
REQ-013 The block SHALL have port instr_ready  input  1  consumer accepts the queue head.
REQ-014 The block SHALL have port instr  output  XLEN  queue-head instruction word.
REQ-015 The block SHALL have port instr_pc  output  XLEN  address of the queue-head instruction.
REQ-016 The block SHALL have port count  output  $clog2(DEPTH+1)  number of occupied queue entries.

Function
REQ-017 The block SHALL implement two states: FETCH (normal) and DRAIN (discarding one stale in-flight response).
REQ-018 The block SHALL hold fetch_pc, a register whose bits [1:0] are always 0, and SHALL drive mem_addr = fetch_pc.
REQ-019 In FETCH, mem_read SHALL equal (count < DEPTH); in DRAIN, mem_read SHALL be 1.
REQ-020 Once mem_read is asserted, mem_read and mem_addr SHALL remain stable until the cycle mem_resp=1 (no abort).
REQ-021 In FETCH with mem_read=1, mem_resp=1 and redirect=0, the block SHALL push {fetch_pc, mem_rdata} at the tail and set fetch_pc <= fetch_pc + 4, modulo 2^XLEN.
REQ-022 After a mem_resp, a new request SHALL be issuable the next cycle, giving a peak throughput of one word per cycle.
REQ-023 A pushed entry SHALL become visible at the head (instr_valid=1) no earlier than the cycle after the push.
REQ-024 The consumer handshake SHALL be: pop the head when instr_valid & instr_ready; instr and instr_pc SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; a push SHALL never occur while count=DEPTH.
REQ-026 The read/write pointers SHALL wrap modulo DEPTH.
REQ-027 On redirect=1, the block SHALL empty the queue (count <= 0, instr_valid=0 next cycle), ignoring any simultaneous pop or push.
REQ-028 On redirect=1 with no outstanding request, or with mem_resp=1 the same cycle, the block SHALL set fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00} and enter or stay in FETCH.
REQ-029 On redirect=1 with mem_read=1 and mem_resp=0, the block SHALL store the aligned target in pending_pc and enter DRAIN.
REQ-030 In DRAIN, a further redirect SHALL overwrite pending_pc.
REQ-031 In DRAIN, on mem_resp=1 the block SHALL discard the data, set fetch_pc <= pending_pc (or the aligned redirect_pc if redirect=1 that cycle) and return to FETCH.

Reset
REQ-032 While rst_n=0, the block SHALL hold state=FETCH, fetch_pc=RESET_PC, pending_pc=0, pointers=0, count=0, instr_valid=0, and mem_read=0 (forced low during reset).
REQ-033 In the first cycle after rst_n rises, the block SHALL drive mem_read=1 and mem_addr=RESET_PC.
REQ-034 Reset asserted mid-transaction SHALL abandon the request, with no further response expected.

Verification
REQ-035 Scenario: reset release, memory responds in 1 cycle, instr_ready=1 -> mem_addr sequence 0x1000, 0x1004, 0x1008, and instr_pc follows the same sequence one word per cycle.
REQ-036 Scenario: instr_ready=0, responses continuous -> exactly 4 words pushed, count=4, mem_read=0 with mem_addr=0x1010; one pop -> mem_read=1 next cycle.
REQ-037 Scenario: redirect to 0x2002 while idle with count=3 -> count=0 next cycle, mem_addr=0x2000, first delivered instr_pc=0x2000.
REQ-038 Scenario: redirect to 0x3000 while a request to 0x1008 is pending for 5 cycles -> mem_addr holds 0x1008 until mem_resp, data is never delivered, next mem_addr=0x3000.
REQ-039 Scenario: redirect in DRAIN to 0x4000, then redirect to 0x5000, then mem_resp -> next mem_addr=0x5000.
REQ-040 Scenario: push and pop in the same cycle at count=2 -> count stays 2, and pointer wrap with data order is preserved over 10 words.
